// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
// Shared constants and helpers for the chunked pipelined adder.
//   SAT_WRAP / SAT_CLAMP : values for the pipe_adder SAT parameter
//   calc_stages()        : number of pipeline stages for a WIDTH/CHUNK pair
package pipe_adder_pkg;

    localparam int SAT_WRAP  = 0;  // sum wraps modulo 2^WIDTH
    localparam int SAT_CLAMP = 1;  // sum clamps to all-ones on carry out

    // One stage per CHUNK-bit slice of the operands.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if
// Valid/ready operand and result channels of the pipelined adder.
//   in_valid/in_ready  : operand handshake (a, b, cin)
//   out_valid/out_ready: result handshake (sum, cout)
// Modports:
//   master : the block feeding operands and consuming results
//   slave  : the adder itself
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipe_adder_chunk.sv
// adder_chunk
// Purely combinational CHUNK-bit adder slice used by each pipeline stage.
//   x, y : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out of the slice
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
// Unsigned WIDTH-bit adder split into WIDTH/CHUNK pipeline stages with a
// valid/ready handshake and a single global stall.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, clears valid bits and data
//   bus  : pipe_adder_if slave (operands in, result out); its WIDTH must
//          match this module's WIDTH
// Parameters: WIDTH (operand/sum bits), CHUNK (bits per stage),
//             SAT (SAT_WRAP or SAT_CLAMP).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8,
    parameter int SAT   = SAT_WRAP
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_width
        $fatal(1, "pipe_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
    if (SAT != SAT_WRAP && SAT != SAT_CLAMP) begin : g_bad_sat
        $fatal(1, "pipe_adder: SAT must be 0 or 1, got %0d", SAT);
    end

    // Stage k register contents: sum_reg[k] has chunks 0..k valid, while
    // a_reg/b_reg[k] carry the untouched operands forward so that chunks
    // k+1.. are available to later stages (skew registers).
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] c_reg;
    logic [WIDTH-1:0]  sum_reg [STAGES];
    logic [WIDTH-1:0]  a_reg   [STAGES];
    logic [WIDTH-1:0]  b_reg   [STAGES];

    logic [STAGES-1:0]            c_next;
    logic [STAGES-1:0][WIDTH-1:0] sum_next;
    logic [STAGES-1:0][WIDTH-1:0] a_next;
    logic [STAGES-1:0][WIDTH-1:0] b_next;

    logic advance;
    logic out_valid;

    assign out_valid = valid_reg[STAGES-1];
    assign advance   = !out_valid || bus.out_ready;

    // While rst is high nothing is accepted anyway (reset wins in the
    // register update), so ready is forced high to avoid back-pressuring a
    // source across a reset.
    assign bus.in_ready  = advance || rst;
    assign bus.out_valid = out_valid;
    assign bus.cout      = c_reg[STAGES-1];
    assign bus.sum       = (SAT == SAT_CLAMP && c_reg[STAGES-1]) ? '1 : sum_reg[STAGES-1];

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] base_sum;
        logic [WIDTH-1:0] merged;
        logic [CHUNK-1:0] chunk_sum;
        logic             carry_in;

        if (gi == 0) begin : g_head
            assign op_a     = bus.a;
            assign op_b     = bus.b;
            assign carry_in = bus.cin;
            assign base_sum = '0;
        end else begin : g_body
            assign op_a     = a_reg[gi-1];
            assign op_b     = b_reg[gi-1];
            assign carry_in = c_reg[gi-1];
            assign base_sum = sum_reg[gi-1];
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .x  (op_a[gi*CHUNK +: CHUNK]),
            .y  (op_b[gi*CHUNK +: CHUNK]),
            .ci (carry_in),
            .s  (chunk_sum),
            .co (c_next[gi])
        );

        // Lower sum chunks ride along unchanged; this stage fills in its own.
        always_comb begin
            merged = base_sum;
            merged[gi*CHUNK +: CHUNK] = chunk_sum;
        end

        assign sum_next[gi] = merged;
        assign a_next[gi]   = op_a;
        assign b_next[gi]   = op_b;
    end

    // All stages shift together or hold together; bubbles keep their slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            c_reg     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_reg[k] <= '0;
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
            end
        end else if (advance) begin
            valid_reg[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_reg[k] <= valid_reg[k-1];
            end
            c_reg <= c_next;
            for (int k = 0; k < STAGES; k++) begin
                sum_reg[k] <= sum_next[k];
                a_reg[k]   <= a_next[k];
                b_reg[k]   <= b_next[k];
            end
        end
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per pipeline stage; WIDTH SHALL be a non-zero multiple of CHUNK, else elaboration fatal.
REQ-003 Parameter SAT, default 0, 0 = wrap-around sum, 1 = unsigned saturation to all-ones on overflow.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand set a, b, cin valid.
REQ-007 in_ready  output  1  pipeline accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A, unsigned.
REQ-009 b  input  WIDTH  operand B, unsigned.
REQ-010 cin  input  1  carry-in to bit 0.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of bit WIDTH-1; raw, independent of SAT.

Function
REQ-015 STAGES = WIDTH/CHUNK; latency SHALL be exactly STAGES cycles from input handshake to out_valid with no stall.
REQ-016 Stage k (0..STAGES-1) SHALL add chunk k of a and b plus the carry registered by stage k-1 (cin for k=0), registering chunk-k sum and carry.
REQ-017 Upper operand chunks SHALL be carried forward unmodified in skew registers; lower sum chunks are delayed so all chunks of one result reach the output together.
REQ-018 Each stage holds a valid bit; advance = !out_valid || out_ready; when advance is 1 all stages shift, otherwise all stages hold (global stall).
REQ-019 in_ready SHALL equal advance (combinational from out_valid, out_ready); an input transfer occurs when in_valid && in_ready.
REQ-020 Empty stages (bubbles) SHALL not be compressed; a bubble occupies its slot through the pipeline.
REQ-021 Output transfer occurs when out_valid && out_ready; sum, cout, out_valid SHALL stay stable while out_valid && !out_ready.
REQ-022 SAT=0: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of full result.
REQ-023 SAT=1: if cout = 1, sum = all ones; else sum as SAT=0.
REQ-024 Simultaneous input and output transfer in one cycle SHALL sustain throughput of one result per cycle.
REQ-025 Results SHALL emerge in acceptance order; no drop, no duplication.
REQ-026 STAGES = 1 (CHUNK = WIDTH) SHALL behave as a single registered adder with the same handshake.

Reset
REQ-027 rst sampled high at a rising edge SHALL clear every valid bit; out_valid = 0 in the following cycle.
REQ-028 After reset sum = 0, cout = 0; data/carry registers cleared.
REQ-029 rst mid-operation SHALL discard all in-flight results; an input presented with rst high SHALL not be accepted; in_ready SHALL be 1 during and after reset.

Structure
REQ-030 Package pipe_adder_pkg SHALL hold the SAT mode constants (SAT_WRAP = 0, SAT_CLAMP = 1) and the function computing STAGES.
REQ-031 One sub-module adder_chunk (CHUNK-bit combinational add, inputs x, y, ci, outputs s, co) SHALL be instantiated once per stage via generate.
REQ-032 No latches; one always_ff for pipeline state, generate loop for stages.

Verification (WIDTH=16, CHUNK=8 unless stated)
REQ-033 a=1000, b=2000, cin=0, out_ready=1 -> after 2 cycles out_valid=1, sum=3000, cout=0.
REQ-034 a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, cout=0 (inter-stage carry).
REQ-035 a=16'hFFFF, b=16'h0002, cin=1: SAT=0 -> sum=16'h0002, cout=1; SAT=1 -> sum=16'hFFFF, cout=1.
REQ-036 Stream 10 back-to-back operand sets, out_ready low 3 cycles mid-stream -> in_ready low during stall, output held stable, all 10 results in order.
REQ-037 Assert rst with 2 results in flight -> out_valid=0 next cycle, sum=0, no stale result later emerges.
REQ-038 WIDTH=8, CHUNK=8: a=10, b=20 -> sum=30 after 1 cycle; WIDTH=32, CHUNK=8: a=32'hFFFFFFFF, b=1 -> sum=0, cout=1 after 4 cycles.
